// File: rtl/sparse_pp_accumulator_if.sv
// ---------------------------------------------------------------------------
// sparse_pp_accumulator_if
//
// Purpose: bundles the operation-start, partial-product beat and result
//          signals of the sparse partial-product accumulator. The producer
//          side (digit encoder / operand prefetch / result consumer) uses the
//          master modport. The accumulator uses the slave modport.
//
// Parameters:
//   B_WIDTH    signed width of multiplicand B
//   ACC_WIDTH  signed width of the accumulator and result
//
// Signals (direction seen from the master):
//   start        out  begin a multiplication (honoured in IDLE / DONE)
//   cal_cycle    out  number of nonzero radix-4 digits, 0..4 (5..7 -> 4)
//   operand_b    out  signed multiplicand B, sampled with start
//   pp_valid     out  a partial-product beat is present this cycle
//   pp_index     out  digit code: 00=-2B, 01=+B, 10=+2B, 11=-B
//   pp_position  out  digit position p, term weighted by 4^p
//   result       in   signed product, held until the next update
//   result_valid in   one-cycle pulse when result is updated
//   busy         in   high while partial products are being accumulated
// ---------------------------------------------------------------------------
interface sparse_pp_accumulator_if #(
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 2 * B_WIDTH
);

  logic                        start;
  logic        [2:0]           cal_cycle;
  logic signed [B_WIDTH-1:0]   operand_b;
  logic                        pp_valid;
  logic        [1:0]           pp_index;
  logic        [1:0]           pp_position;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        result_valid;
  logic                        busy;

  modport master (
    output start,
    output cal_cycle,
    output operand_b,
    output pp_valid,
    output pp_index,
    output pp_position,
    input  result,
    input  result_valid,
    input  busy
  );

  modport slave (
    input  start,
    input  cal_cycle,
    input  operand_b,
    input  pp_valid,
    input  pp_index,
    input  pp_position,
    output result,
    output result_valid,
    output busy
  );

endinterface

// File: rtl/sparse_pp_accumulator.sv
// ---------------------------------------------------------------------------
// sparse_pp_accumulator
//
// Purpose: consumer end of the sparse Booth-digit stream inside the sparse
//          PE. A multiplication starts by latching operand B and the number
//          of nonzero radix-4 digits. After that, one beat (digit code,
//          digit position) arrives per nonzero digit, in any order and with
//          any gaps. Each beat is turned into a shifted partial product of B
//          and added into a modulo-2^ACC_WIDTH accumulator. When the last
//          beat has been taken, the signed product is presented on result
//          with a one-cycle result_valid pulse.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears all state)
//   bus    slave modport of sparse_pp_accumulator_if:
//            start / cal_cycle / operand_b   operation start
//            pp_valid / pp_index / pp_position   partial-product beats
//            result / result_valid / busy    registered outputs
//
// Timing: start accepted at cycle 0 with k nonzero digits. busy is high
// from cycle 1, and beats are taken from cycle 1 onward. The cycle after
// the last beat is DONE, where result/result_valid are already registered.
// A start in the DONE cycle begins the next operation with no idle cycle
// between the two. k = 0 goes directly to DONE with result = 0.
// ---------------------------------------------------------------------------
module sparse_pp_accumulator #(
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 2 * B_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sparse_pp_accumulator_if.slave  bus
);

  // The largest product magnitude is 170*|B|max (digits -2,-2,-2,-2 at
  // positions 0..3), so the accumulator needs 8 bits above B.
  if (ACC_WIDTH < B_WIDTH + 8) begin : g_acc_width_check
    $error("sparse_pp_accumulator: ACC_WIDTH must be at least B_WIDTH+8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Digit count: values above 4 cannot occur for a B_WIDTH-digit radix-4
  // recoding here, so they are clamped to 4.
  // -------------------------------------------------------------------------
  function automatic logic [2:0] f_clamp_count(input logic [2:0] count);
    logic [2:0] clamped;
    clamped = (count > 3'd4) ? 3'd4 : count;
    return clamped;
  endfunction

  // -------------------------------------------------------------------------
  // Partial-product term: sign-extended B, scaled by the Booth digit
  // {-2,+1,+2,-1}, and shifted left by 2*p (weight 4^p). All arithmetic
  // wraps modulo 2^ACC_WIDTH, and no saturation is applied.
  // -------------------------------------------------------------------------
  function automatic logic signed [ACC_WIDTH-1:0] f_term(
    input logic signed [B_WIDTH-1:0] b,
    input logic        [1:0]         index,
    input logic        [1:0]         position
  );
    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] scaled;
    b_ext = {{(ACC_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
    case (index)
      2'b00:   scaled = -(b_ext <<< 1);
      2'b01:   scaled = b_ext;
      2'b10:   scaled = b_ext <<< 1;
      default: scaled = -b_ext;
    endcase
    return scaled <<< {position, 1'b0};
  endfunction

  state_t                      r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [B_WIDTH-1:0]   r_b;
  logic        [2:0]           r_remaining;
  logic signed [ACC_WIDTH-1:0] r_result;
  logic                        r_result_valid;
  logic                        r_busy;

  logic        [2:0]           w_count;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_acc_next;

  assign w_count    = f_clamp_count(bus.cal_cycle);
  assign w_term     = f_term(r_b, bus.pp_index, bus.pp_position);
  assign w_acc_next = r_acc + w_term;

  // -------------------------------------------------------------------------
  // Control FSM and datapath registers. result/result_valid are loaded on
  // the transition into DONE, so they are valid during the DONE cycle itself.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_b            <= '0;
      r_remaining    <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // Beats seen here, including the start cycle, are ignored.
          if (bus.start) begin
            r_acc       <= '0;
            r_b         <= bus.operand_b;
            r_remaining <= w_count;
            if (w_count == 3'd0) begin
              r_state        <= S_DONE;
              r_result       <= '0;
              r_result_valid <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_ACCUM: begin
          // start is deliberately not looked at while accumulating.
          if (bus.pp_valid) begin
            r_acc       <= w_acc_next;
            r_remaining <= r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              r_state        <= S_DONE;
              r_busy         <= 1'b0;
              r_result       <= w_acc_next;
              r_result_valid <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;

endmodule
